// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned N_REQ = 3;

    localparam logic [1:0] IF_PORT   = 2'd0;
    localparam logic [1:0] DATA_PORT = 2'd1;
    localparam logic [1:0] EXT_PORT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Round-robin successor; any out-of-range index wraps to IFETCH.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        if (p == IF_PORT)
            return DATA_PORT;
        else if (p == DATA_PORT)
            return EXT_PORT;
        else
            return IF_PORT;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [1:0] p);
        return N_REQ'(1) << p;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter, grouped as one interface.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    import mem_arb_pkg::*;

    logic [N_REQ-1:0]             REQ;
    logic [N_REQ-1:0]             WE;
    logic [N_REQ-1:0][ADDR_W-1:0] ADDR;
    logic [N_REQ-1:0][DATA_W-1:0] WDATA;
    logic [N_REQ-1:0]             GNT;
    logic [N_REQ-1:0]             DONE;
    logic [DATA_W-1:0]            RDATA;
    logic [ADDR_W-1:0]            MEM_ADDR;
    logic [DATA_W-1:0]            MEM_WDATA;
    logic                         MEM_WE;
    logic [DATA_W-1:0]            MEM_RDATA;
    logic                         BUSY;
    logic [1:0]                   OWNER;

    modport master (
        output REQ, WE, ADDR, WDATA, MEM_RDATA,
        input  GNT, DONE, RDATA, MEM_ADDR, MEM_WDATA, MEM_WE, BUSY, OWNER
    );

    modport slave (
        input  REQ, WE, ADDR, WDATA, MEM_RDATA,
        output GNT, DONE, RDATA, MEM_ADDR, MEM_WDATA, MEM_WE, BUSY, OWNER
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: searches from the port after last_i.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       last_i,
    output logic [1:0]       winner_o,
    output logic             valid_o
);

    logic [1:0] c0, c1, c2;

    always_comb begin
        c0       = next_port(last_i);
        c1       = next_port(c0);
        c2       = next_port(c1);
        winner_o = IF_PORT;
        valid_o  = 1'b1;
        if (req_i[c0])
            winner_o = c0;
        else if (req_i[c1])
            winner_o = c1;
        else if (req_i[c2])
            winner_o = c2;
        else
            valid_o = 1'b0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester round-robin arbiter in front of a fixed-latency synchronous memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    mem_arbiter_if.slave bus
);

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        pick_win;
    logic              pick_vld;
    logic [N_REQ-1:0]  gnt, done;
    logic              mem_we;

    rr_picker u_picker (
        .req_i    (bus.REQ),
        .last_i   (last_q),
        .winner_o (pick_win),
        .valid_o  (pick_vld)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            last_q  <= EXT_PORT;
            owner_q <= IF_PORT;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt     = '0;
        done    = '0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ACCESS;
                    owner_d = pick_win;
                    last_d  = pick_win;
                    cnt_d   = '0;
                    we_d    = bus.WE[pick_win];
                    addr_d  = bus.ADDR[pick_win];
                    wdata_d = bus.WDATA[pick_win];
                end
            end
            ACCESS: begin
                if (cnt_q == '0)
                    gnt = onehot(owner_q);
                if (we_q) begin
                    mem_we  = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == LAT_M1) begin
                    rdata_d = bus.MEM_RDATA;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP: begin
                done    = onehot(owner_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from the state register so reset drops them without waiting for a clock.
    assign bus.GNT       = gnt;
    assign bus.DONE      = done;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.RDATA     = rdata_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.OWNER     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic CLK;
    logic RESET_N;
    int unsigned total = 0;
    int unsigned bad   = 0;

    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ba ();
    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bb ();

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) u_a (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (ba.slave)
    );

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(3)) u_b (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bb.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] order [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    initial begin
        RESET_N      = 1'b0;
        ba.REQ       = '0;  bb.REQ       = '0;
        ba.WE        = '0;  bb.WE        = '0;
        ba.ADDR      = '0;  bb.ADDR      = '0;
        ba.WDATA     = '0;  bb.WDATA     = '0;
        ba.MEM_RDATA = '0;  bb.MEM_RDATA = '0;
        tick();
        tick();
        chk("rst_gnt",   64'(ba.GNT),  64'h0);
        chk("rst_done",  64'(ba.DONE), 64'h0);
        chk("rst_memwe", 64'(ba.MEM_WE), 64'h0);
        chk("rst_busy",  64'(ba.BUSY), 64'h0);
        chk("rst_owner", 64'(ba.OWNER), 64'h0);
        chk("rst_rdata", ba.RDATA, 64'h0);
        chk("rst_maddr", ba.MEM_ADDR, 64'h0);
        chk("rst_mwdat", ba.MEM_WDATA, 64'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();

        // IFETCH read at RD_LAT=1
        ba.REQ = 3'b001;  ba.ADDR[0] = 64'h40;
        tick();
        chk("if_gnt",   64'(ba.GNT), 64'h1);
        chk("if_maddr", ba.MEM_ADDR, 64'h40);
        chk("if_busy",  64'(ba.BUSY), 64'h1);
        chk("if_memwe", 64'(ba.MEM_WE), 64'h0);
        ba.MEM_RDATA = 64'h13;  ba.REQ = '0;
        tick();
        chk("if_done",  64'(ba.DONE), 64'h1);
        chk("if_gnt0",  64'(ba.GNT), 64'h0);
        chk("if_rdata", ba.RDATA, 64'h13);
        tick();
        chk("if_idle",  64'(ba.BUSY), 64'h0);
        chk("if_done0", 64'(ba.DONE), 64'h0);

        // DATA write
        ba.REQ = 3'b010;  ba.WE = 3'b010;  ba.ADDR[1] = 64'h100;  ba.WDATA[1] = 64'hDEADBEEF;
        tick();
        chk("wr_gnt",   64'(ba.GNT), 64'h2);
        chk("wr_memwe", 64'(ba.MEM_WE), 64'h1);
        chk("wr_maddr", ba.MEM_ADDR, 64'h100);
        chk("wr_mwdat", ba.MEM_WDATA, 64'hDEADBEEF);
        ba.REQ = '0;  ba.WE = '0;
        tick();
        chk("wr_memwe0", 64'(ba.MEM_WE), 64'h0);
        chk("wr_done",   64'(ba.DONE), 64'h2);
        chk("wr_rdhold", ba.RDATA, 64'h13);
        tick();

        // All three requesting from reset: IFETCH first, then rotate
        RESET_N = 1'b0;
        #1;
        @(negedge CLK);
        RESET_N = 1'b1;
        ba.REQ = 3'b111;  ba.WE = '0;  ba.MEM_RDATA = 64'hA5;
        ba.ADDR[0] = 64'h1000;  ba.ADDR[1] = 64'h2000;  ba.ADDR[2] = 64'h3000;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k),   64'(ba.GNT), 64'(onehot(order[k])));
            chk($sformatf("rr_owner%0d", k), 64'(ba.OWNER), 64'(order[k]));
            chk($sformatf("rr_maddr%0d", k), ba.MEM_ADDR, 64'h1000 * (64'(order[k]) + 64'd1));
            tick();
            chk($sformatf("rr_done%0d", k),  64'(ba.DONE), 64'(onehot(order[k])));
            tick();
            chk($sformatf("rr_idle%0d", k),  64'(ba.BUSY), 64'h0);
        end
        ba.REQ = '0;

        // EXT read at RD_LAT=3
        bb.REQ = 3'b100;  bb.ADDR[2] = 64'h8;
        tick();
        chk("l3_gnt",   64'(bb.GNT), 64'h4);
        chk("l3_maddr1", bb.MEM_ADDR, 64'h8);
        bb.REQ = '0;  bb.MEM_RDATA = 64'h111;
        tick();
        chk("l3_gnt0",  64'(bb.GNT), 64'h0);
        chk("l3_maddr2", bb.MEM_ADDR, 64'h8);
        chk("l3_busy",  64'(bb.BUSY), 64'h1);
        bb.MEM_RDATA = 64'h222;
        tick();
        chk("l3_maddr3", bb.MEM_ADDR, 64'h8);
        chk("l3_nodone", 64'(bb.DONE), 64'h0);
        bb.MEM_RDATA = 64'h333;
        tick();
        chk("l3_done",  64'(bb.DONE), 64'h4);
        chk("l3_rdata", bb.RDATA, 64'h333);
        bb.MEM_RDATA = 64'h444;
        tick();
        chk("l3_idle",  64'(bb.BUSY), 64'h0);
        chk("l3_rhold", bb.RDATA, 64'h333);

        // Reset in the ACCESS cycle of a write
        ba.REQ = 3'b010;  ba.WE = 3'b010;  ba.ADDR[1] = 64'h200;  ba.WDATA[1] = 64'h55;
        tick();
        chk("ra_memwe1", 64'(ba.MEM_WE), 64'h1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("ra_memwe0", 64'(ba.MEM_WE), 64'h0);
        chk("ra_busy",   64'(ba.BUSY), 64'h0);
        ba.REQ = '0;  ba.WE = '0;
        tick();
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        chk("ra_nodone", 64'(ba.DONE), 64'h0);
        chk("ra_busy2",  64'(ba.BUSY), 64'h0);
        ba.REQ = 3'b111;
        tick();
        chk("ra_gnt_if", 64'(ba.GNT), 64'h1);
        ba.REQ = '0;
        tick();
        chk("ra_done_if", 64'(ba.DONE), 64'h1);
        tick();

        // DATA read with REQ dropped right after arbitration
        ba.REQ = 3'b010;  ba.ADDR[1] = 64'h300;  ba.MEM_RDATA = 64'h77;
        tick();
        chk("dr_gnt",  64'(ba.GNT), 64'h2);
        ba.REQ = '0;
        tick();
        chk("dr_done", 64'(ba.DONE), 64'h2);
        chk("dr_rdata", ba.RDATA, 64'h77);
        tick();
        chk("dr_gnt0", 64'(ba.GNT), 64'h0);
        tick();
        chk("dr_nogrant", 64'(ba.GNT), 64'h0);
        chk("dr_idle",    64'(ba.BUSY), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
